// File: rtl/step_sequencer_pkg.sv
// Shared constants and state encoding for the instruction-stepping sequencer.
package step_sequencer_pkg;

  localparam int INSTR_W = 32;
  localparam logic [INSTR_W-1:0] NOOP_DEFAULT = 32'h1300_0000;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_STEP    = 2'd1,
    ST_DUMP    = 2'd2,
    ST_WAIT_TX = 2'd3
  } seq_state_t;

endpackage

// File: rtl/step_sequencer_instr_fifo.sv
// Show-ahead synchronous instruction FIFO; a push while full is taken only
// when a pop happens in the same cycle, otherwise the word is dropped.
module instr_fifo
  import step_sequencer_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = INSTR_W
) (
  input  logic                           clk12,
  input  logic                           rst,
  input  logic                           push,
  input  logic [WIDTH-1:0]               din,
  input  logic                           pop,
  output logic [WIDTH-1:0]               dout,
  output logic                           full,
  output logic                           empty,
  output logic [$clog2(DEPTH+1)-1:0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic [CW-1:0]    count_q;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign dout    = mem[rd_ptr];
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);

  // Storage is not reset; only the pointers and occupancy define validity.
  always_ff @(posedge clk12) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk12) begin
    if (rst) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      count_q <= count_q + CW'(push_ok) - CW'(pop_ok);
    end
  end

endmodule

// File: rtl/step_sequencer.sv
// Queues received instructions and steps the CPU clock once per instruction,
// then requests a register-file dump and waits for the transmitter.
module step_sequencer
  import step_sequencer_pkg::*;
#(
  parameter int                 DEPTH       = 4,
  parameter int                 HALF_CYCLES = 10,
  parameter int                 INJECT_HALF = 2,
  parameter logic [INSTR_W-1:0] NOOP        = NOOP_DEFAULT
) (
  input  logic                         clk12,
  input  logic                         rst,
  input  logic [31:0]                  instr_in,
  input  logic                         instr_rcv,
  input  logic                         tx_ready,
  output logic                         clk_proc,
  output logic [31:0]                  inst_out,
  output logic                         send_regfile,
  output logic                         busy,
  output logic [$clog2(DEPTH+1)-1:0]   fifo_count,
  output logic                         overflow
);

  localparam int CNT_W = $clog2(HALF_CYCLES);

  seq_state_t        state;
  logic [CNT_W-1:0]  cnt;
  logic [31:0]       cur_instr;
  logic              wait_first;
  logic [31:0]       fifo_head;
  logic              fifo_full;
  logic              fifo_empty;
  logic              fifo_pop;

  assign fifo_pop = (state == ST_IDLE) && !fifo_empty;

  instr_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (INSTR_W)
  ) u_fifo (
    .clk12 (clk12),
    .rst   (rst),
    .push  (instr_rcv),
    .din   (instr_in),
    .pop   (fifo_pop),
    .dout  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_ff @(posedge clk12) begin
    if (rst) begin
      state        <= ST_IDLE;
      cnt          <= '0;
      cur_instr    <= NOOP;
      clk_proc     <= 1'b1;
      send_regfile <= 1'b0;
      wait_first   <= 1'b0;
      overflow     <= 1'b0;
    end else begin
      send_regfile <= 1'b0;
      if (instr_rcv && fifo_full && !fifo_pop) overflow <= 1'b1;
      case (state)
        ST_IDLE: begin
          if (!fifo_empty) begin
            cur_instr <= fifo_head;
            cnt       <= '0;
            clk_proc  <= 1'b0;
            state     <= ST_STEP;
          end
        end
        ST_STEP: begin
          if (cnt == CNT_W'(HALF_CYCLES - 1)) begin
            clk_proc <= 1'b1;
            cnt      <= '0;
            state    <= ST_DUMP;
          end else begin
            clk_proc <= ~clk_proc;
            cnt      <= cnt + CNT_W'(1);
          end
        end
        ST_DUMP: begin
          if (tx_ready) begin
            send_regfile <= 1'b1;
            wait_first   <= 1'b1;
            state        <= ST_WAIT_TX;
          end
        end
        ST_WAIT_TX: begin
          // The transmitter may still report idle in the cycle of the request.
          if (wait_first) begin
            wait_first <= 1'b0;
          end else if (tx_ready) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign inst_out = ((state == ST_STEP) && (int'(cnt) < INJECT_HALF)) ? cur_instr : NOOP;
  assign busy     = (state != ST_IDLE);

endmodule
